// File: rtl/cpu_ctrl_seq.sv
// Instruction sequencer for the 8-bit CPU: fetch/decode/execute FSM that drives the ALU and A/B loads.
// Optional single-step gating is enabled with `define CPU_CTRL_STEP_EN (adds i_step and a STEP_WAIT state).
module cpu_ctrl_seq #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rstn,
`ifdef CPU_CTRL_STEP_EN
  input  logic       i_step,
`endif
  input  logic       i_run,
  output logic       o_mem_req,
  output logic [7:0] o_mem_addr,
  input  logic       i_mem_ready,
  input  logic [7:0] i_mem_rdata,
  input  logic [3:0] i_flags,
  output logic [3:0] o_alu_op,
  output logic       o_alu_cin,
  output logic       o_alu_sel,
  output logic       o_flag_sel,
  output logic [7:0] o_imm_data,
  output logic       o_imm_oe,
  output logic       o_a_ld,
  output logic       o_b_ld,
  output logic [7:0] o_pc,
  output logic       o_halted
);

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_OPND,
    S_ALU_F,
    S_ALU_W,
    S_LDI_W,
    S_JMP_X,
    S_HALT
`ifdef CPU_CTRL_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

`ifdef CPU_CTRL_STEP_EN
  localparam state_t S_RETIRE = S_STEP_WAIT;
`else
  localparam state_t S_RETIRE = S_FETCH;
`endif

  state_t          state_q, state_d;
  logic [DW-1:0]   ir_q, ir_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   opnd_q, opnd_d;
  logic            jmp_take;

  logic            req_d, alu_cin_d, alu_sel_d, flag_sel_d, imm_oe_d, a_ld_d, b_ld_d, halted_d;
  logic [OPW-1:0]  alu_op_d;
  logic [DW-1:0]   imm_data_d;

  // Jump condition against flags {zr,ng,pa,of}
  always_comb begin
    jmp_take = 1'b0;
    case (ir_q[2:0])
      3'd0:    jmp_take = 1'b1;
      3'd1:    jmp_take = i_flags[3];
      3'd2:    jmp_take = ~i_flags[3];
      3'd3:    jmp_take = i_flags[2];
      3'd4:    jmp_take = ~i_flags[2];
      3'd5:    jmp_take = i_flags[1];
      3'd6:    jmp_take = i_flags[0];
      default: jmp_take = 1'b0;
    endcase
  end

  // Next state and datapath updates; outputs are decoded from the next state and registered
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    opnd_d     = opnd_q;
    req_d      = 1'b0;
    alu_op_d   = '0;
    alu_cin_d  = 1'b0;
    alu_sel_d  = 1'b0;
    flag_sel_d = 1'b0;
    imm_data_d = '0;
    imm_oe_d   = 1'b0;
    a_ld_d     = 1'b0;
    b_ld_d     = 1'b0;
    halted_d   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (o_mem_req && i_mem_ready) begin
          ir_d    = i_mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_q[7:6])
          2'b00:   state_d = S_ALU_F;
          2'b01,
          2'b10:   state_d = S_OPND;
          default: state_d = ir_q[0] ? S_HALT : S_RETIRE;
        endcase
      end
      S_OPND: begin
        if (o_mem_req && i_mem_ready) begin
          opnd_d  = i_mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = ir_q[7] ? S_JMP_X : S_LDI_W;
        end
      end
      S_ALU_F: state_d = S_ALU_W;
      S_ALU_W: state_d = S_RETIRE;
      S_LDI_W: state_d = S_RETIRE;
      S_JMP_X: begin
        if (jmp_take) pc_d = opnd_q;
        state_d = S_RETIRE;
      end
      S_HALT:  state_d = S_HALT;
`ifdef CPU_CTRL_STEP_EN
      S_STEP_WAIT: if (i_step) state_d = S_FETCH;
`endif
      default: state_d = S_FETCH;
    endcase

    // A pending fetch request is held until ready regardless of i_run
    case (state_d)
      S_FETCH: req_d = i_run || (state_q == S_FETCH && o_mem_req);
      S_OPND:  req_d = 1'b1;
      S_ALU_F: begin
        flag_sel_d = 1'b1;
        alu_op_d   = ir_d[3:0];
        alu_cin_d  = ir_d[4];
      end
      S_ALU_W: begin
        alu_sel_d = 1'b1;
        alu_op_d  = ir_d[3:0];
        alu_cin_d = ir_d[4];
        a_ld_d    = ~ir_d[5];
        b_ld_d    = ir_d[5];
      end
      S_LDI_W: begin
        imm_oe_d   = 1'b1;
        imm_data_d = opnd_d;
        a_ld_d     = ~ir_d[0];
        b_ld_d     = ir_d[0];
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  // State, architectural registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      pc_q       <= RESET_PC;
      opnd_q     <= '0;
      o_mem_req  <= 1'b0;
      o_alu_op   <= '0;
      o_alu_cin  <= 1'b0;
      o_alu_sel  <= 1'b0;
      o_flag_sel <= 1'b0;
      o_imm_data <= '0;
      o_imm_oe   <= 1'b0;
      o_a_ld     <= 1'b0;
      o_b_ld     <= 1'b0;
      o_halted   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      opnd_q     <= opnd_d;
      o_mem_req  <= req_d;
      o_alu_op   <= alu_op_d;
      o_alu_cin  <= alu_cin_d;
      o_alu_sel  <= alu_sel_d;
      o_flag_sel <= flag_sel_d;
      o_imm_data <= imm_data_d;
      o_imm_oe   <= imm_oe_d;
      o_a_ld     <= a_ld_d;
      o_b_ld     <= b_ld_d;
      o_halted   <= halted_d;
    end
  end

  assign o_pc       = pc_q;
  assign o_mem_addr = pc_q;

endmodule
